cp0: RTL

CP0 -- requirements
Module: cp0

---
 rtl/cp0_if.sv | 25 ++
 rtl/cp0.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cp0_if.sv
// Coprocessor-0 bus: mtc0/mfc0 access, exception inputs and redirect outputs.
// The cp0 block sits on the slave modport; the pipeline drives the master side.
interface cp0_if;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_in;
   logic [31:0] cp0_out;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        exl_clr;
   logic        req;
   logic [31:0] epc_out;

   modport slave (
      input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
      output cp0_out, req, epc_out
   );

   modport master (
      output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
      input  cp0_out, req, epc_out
   );
endinterface

// File: rtl/cp0.sv
// MIPS-style coprocessor 0: SR, Cause, EPC and PRId, with exception and interrupt entry.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0 (
   input logic   clk,
   input logic   reset,
   cp0_if.slave  bus
);
   localparam logic [4:0]  ADDR_COUNT   = 5'd9;
   localparam logic [4:0]  ADDR_COMPARE = 5'd11;
   localparam logic [4:0]  ADDR_SR      = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
   localparam logic [4:0]  ADDR_EPC     = 5'd14;
   localparam logic [4:0]  ADDR_PRID    = 5'd15;
   localparam logic [31:0] PRID_VALUE   = 32'h2023_1123;

   logic [5:0]  im_r;
   logic        exl_r;
   logic        ie_r;
   logic        bd_r;
   logic [5:0]  ip_r;
   logic [4:0]  exc_code_r;
   logic [31:0] epc_r;

   logic        int_req_s;
   logic        exc_req_s;
   logic        req_s;
   logic        wr_s;
   logic        timer_ip_s;
   logic [31:0] sr_s;
   logic [31:0] cause_s;
   logic [31:0] epc_next_s;
   logic [31:0] rd_data_s;
   logic        unused_bits_s;

   assign int_req_s  = (|(ip_r & im_r)) & ie_r & ~exl_r;
   assign exc_req_s  = (bus.exc_code_in != 5'd0) & ~exl_r;
   assign req_s      = int_req_s | exc_req_s;
   assign wr_s       = bus.en & ~req_s;
   assign epc_next_s = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;

   assign sr_s    = {16'h0000, im_r, 8'h00, exl_r, ie_r};
   assign cause_s = {bd_r, 15'h0000, ip_r, 3'b000, exc_code_r, 2'b00};

   assign unused_bits_s = ^{bus.cp0_in[31:16], bus.cp0_in[9:2]};

`ifdef CP0_TIMER_EN
   logic [31:0] count_r;
   logic [31:0] compare_r;
   logic        timer_flag_r;
   logic [31:0] count_next_s;
   logic        timer_flag_next_s;

   // The flag sets on the edge where Count becomes equal to Compare, so
   // Cause.IP[15] and req rise on that same edge.
   assign count_next_s = (wr_s && (bus.cp0_addr == ADDR_COUNT)) ? bus.cp0_in
                                                               : (count_r + 32'd1);
   assign timer_flag_next_s = (wr_s && (bus.cp0_addr == ADDR_COMPARE)) ? 1'b0 :
                              (timer_flag_r |
                               ((count_next_s == compare_r) && (compare_r != 32'd0)));
   assign timer_ip_s = timer_flag_next_s;

   // Free-running Count, Compare register and sticky compare-match flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r      <= 32'd0;
         compare_r    <= 32'd0;
         timer_flag_r <= 1'b0;
      end else begin
         count_r      <= count_next_s;
         timer_flag_r <= timer_flag_next_s;
         if (wr_s && (bus.cp0_addr == ADDR_COMPARE)) begin
            compare_r <= bus.cp0_in;
         end
      end
   end
`else
   assign timer_ip_s = 1'b0;
`endif

   // mfc0 read mux; unimplemented register numbers read zero.
   always_comb begin
      rd_data_s = 32'd0;
      case (bus.cp0_addr)
`ifdef CP0_TIMER_EN
         ADDR_COUNT:   rd_data_s = count_r;
         ADDR_COMPARE: rd_data_s = compare_r;
`endif
         ADDR_SR:      rd_data_s = sr_s;
         ADDR_CAUSE:   rd_data_s = cause_s;
         ADDR_EPC:     rd_data_s = epc_r;
         ADDR_PRID:    rd_data_s = PRID_VALUE;
         default:      rd_data_s = 32'd0;
      endcase
   end

   // SR, Cause and EPC: exception entry wins over any coincident mtc0 write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_r       <= 6'd0;
         exl_r      <= 1'b0;
         ie_r       <= 1'b0;
         bd_r       <= 1'b0;
         ip_r       <= 6'd0;
         exc_code_r <= 5'd0;
         epc_r      <= 32'd0;
      end else begin
         ip_r <= {bus.hw_int[5] | timer_ip_s, bus.hw_int[4:0]};
         if (req_s) begin
            exl_r      <= 1'b1;
            exc_code_r <= int_req_s ? 5'd0 : bus.exc_code_in;
            bd_r       <= bus.bd_in;
            epc_r      <= epc_next_s;
         end else begin
            if (wr_s && (bus.cp0_addr == ADDR_SR)) begin
               im_r  <= bus.cp0_in[15:10];
               ie_r  <= bus.cp0_in[0];
               exl_r <= bus.cp0_in[1] & ~bus.exl_clr;
            end else if (bus.exl_clr) begin
               exl_r <= 1'b0;
            end
            if (wr_s && (bus.cp0_addr == ADDR_EPC)) begin
               epc_r <= bus.cp0_in;
            end
         end
      end
   end

   assign bus.cp0_out = rd_data_s;
   assign bus.req     = req_s;
   assign bus.epc_out = epc_r;
endmodule
